// File: rtl/axi_lite_selftest_master.sv
`default_nettype none
// ============================================================================
// axi_lite_selftest_master : writes N incrementing words over AXI4-Lite, reads
// them back and raises ERROR on any data mismatch or non-OKAY response. Rev 1.0
// ============================================================================
module axi_lite_selftest_master #(
  parameter int                            C_M_AXI_ADDR_WIDTH         = 32,
  parameter int                            C_M_AXI_DATA_WIDTH         = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int                            C_M_TRANSACTIONS_NUM       = 4,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_M_START_DATA_VALUE       = 32'hAA00_0000
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            INIT_AXI_TXN,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int             IW       = $clog2(C_M_TRANSACTIONS_NUM + 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(C_M_TRANSACTIONS_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_COMPARE = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      init_hist_q, init_hist_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            busy_q, busy_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            bready_q, bready_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                            txn_done_q, txn_done_d;
  logic                            error_q, error_d;

  logic                            w_init_pulse;
  logic                            w_last;
  logic                            w_b_hs;
  logic                            w_r_hs;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   w_word_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   w_word_data;

  assign w_init_pulse = init_hist_q[0] & ~init_hist_q[1];
  assign w_last       = (idx_q == LAST_IDX);
  assign w_b_hs       = bready_q & M_AXI_BVALID;
  assign w_r_hs       = rready_q & M_AXI_RVALID;
  // Same index drives both the write pattern and the read-back expectation.
  assign w_word_addr  = C_M_TARGET_SLAVE_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
  assign w_word_data  = C_M_START_DATA_VALUE + C_M_AXI_DATA_WIDTH'(idx_q);

  always_comb begin
    state_d     = state_q;
    init_hist_d = {init_hist_q[0], INIT_AXI_TXN};
    idx_d       = idx_q;
    busy_d      = busy_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = 1'b0;
    arvalid_d   = arvalid_q;
    rready_d    = 1'b0;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    txn_done_d  = txn_done_q;
    error_d     = error_q;
    case (state_q)
      ST_IDLE: begin
        if (w_init_pulse) begin
          txn_done_d = 1'b0;
          error_d    = 1'b0;
          idx_d      = '0;
          busy_d     = 1'b0;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!busy_q) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = w_word_addr;
          wdata_d   = w_word_data;
          busy_d    = 1'b1;
        end else begin
          if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
          if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
          bready_d = M_AXI_BVALID & ~bready_q;
          if (w_b_hs) begin
            busy_d = 1'b0;
            if (M_AXI_BRESP != 2'b00) error_d = 1'b1;
            if (w_last) begin
              idx_d   = '0;
              state_d = ST_READ;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      ST_READ: begin
        if (!busy_q) begin
          arvalid_d = 1'b1;
          araddr_d  = w_word_addr;
          busy_d    = 1'b1;
        end else begin
          if (arvalid_q && M_AXI_ARREADY) arvalid_d = 1'b0;
          rready_d = M_AXI_RVALID & ~rready_q;
          if (w_r_hs) begin
            busy_d = 1'b0;
            if ((M_AXI_RDATA != w_word_data) || (M_AXI_RRESP != 2'b00)) error_d = 1'b1;
            if (w_last) state_d = ST_COMPARE;
            else        idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_COMPARE: begin
        txn_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      init_hist_q <= 2'b00;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= C_M_TARGET_SLAVE_BASE_ADDR;
      araddr_q    <= C_M_TARGET_SLAVE_BASE_ADDR;
      wdata_q     <= C_M_START_DATA_VALUE;
      txn_done_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_hist_q <= init_hist_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      txn_done_q  <= txn_done_d;
      error_q     <= error_d;
    end
  end

  assign TXN_DONE      = txn_done_q;
  assign ERROR         = error_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_selftest_master.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_selftest_master : randomized AXI4-Lite memory slave, protocol
// monitor and reference expectations around the self-test master.    Rev 1.0
// ============================================================================
module tb_axi_lite_selftest_master;

  localparam int          N       = 4;
  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam logic [31:0] START   = 32'hAA00_0000;
  localparam int          TIMEOUT = 3000;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        init    = 1'b0;
  logic        txn_done, error;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;

  axi_lite_selftest_master dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .INIT_AXI_TXN  (init),
    .TXN_DONE      (txn_done),
    .ERROR         (error),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // slave behaviour knobs; fault indices outside 0..N-1 mean "no fault"
  int max_dly     = 0;
  bit w_first     = 1'b0;
  bit early_rdy   = 1'b0;
  int corrupt_idx = -1;
  int bad_b_idx   = -1;
  int bad_r_idx   = -1;

  int          aw_n, w_n, b_n, ar_n, r_n;
  bit          aw_taken, w_taken, ar_taken, b_drop, r_drop;
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [31:0] wr_addr_cap, wr_data_cap, rd_addr_cap;
  logic [31:0] mem [N];
  logic        last_awv, last_awr, last_wv, last_wr, last_arv, last_arr, last_bready, last_rready;
  logic [31:0] last_awaddr, last_wdata, last_araddr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int rnd(input int hi);
    return int'($urandom_range(32'(hi), 0));
  endfunction

  function automatic int slot(input logic [31:0] addr);
    return int'((addr - BASE) >> 2) % N;
  endfunction

  function automatic bit in_range(input int i);
    return (i >= 0) && (i < N);
  endfunction

  // Reference: any injected fault inside the run makes the sticky error expected.
  function automatic bit expect_error();
    return in_range(corrupt_idx) || in_range(bad_b_idx) || in_range(bad_r_idx);
  endfunction

  task automatic new_wdelays;
    w_dly  = rnd(max_dly);
    aw_dly = w_first ? (w_dly + 1 + rnd(2)) : rnd(max_dly);
    b_dly  = rnd(max_dly);
  endtask

  task automatic new_rdelays;
    ar_dly = rnd(max_dly);
    r_dly  = rnd(max_dly);
  endtask

  task automatic slave_reset;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
    aw_taken = 1'b0; w_taken = 1'b0; ar_taken = 1'b0; b_drop = 1'b0; r_drop = 1'b0;
    last_awv = 1'b0; last_awr = 1'b0; last_wv = 1'b0; last_wr = 1'b0;
    last_arv = 1'b0; last_arr = 1'b0; last_bready = 1'b0; last_rready = 1'b0;
    last_awaddr = 32'h0; last_wdata = 32'h0; last_araddr = 32'h0;
    new_wdelays();
    new_rdelays();
  endtask

  // Protocol rules, evaluated on values seen one cycle apart.
  task automatic monitor;
    if (last_awv) begin
      if (last_awr) check_eq("aw_drop", 64'(awvalid), 64'(0));
      else          check_eq("aw_hold", 64'({awvalid, awaddr == last_awaddr}), 64'(2'b11));
    end
    if (last_wv) begin
      if (last_wr) check_eq("w_drop", 64'(wvalid), 64'(0));
      else         check_eq("w_hold", 64'({wvalid, wdata == last_wdata}), 64'(2'b11));
    end
    if (last_arv) begin
      if (last_arr) check_eq("ar_drop", 64'(arvalid), 64'(0));
      else          check_eq("ar_hold", 64'({arvalid, araddr == last_araddr}), 64'(2'b11));
    end
    if (awvalid && !last_awv)
      check_eq("aw_start", 64'({wvalid, !last_wv, aw_n == b_n, ar_n == r_n}), 64'(4'b1111));
    if (arvalid && !last_arv)
      check_eq("ar_start", 64'({aw_n == b_n, ar_n == r_n}), 64'(2'b11));
    if (bready) check_eq("bready_pulse", 64'(last_bready), 64'(0));
    if (rready) check_eq("rready_pulse", 64'(last_rready), 64'(0));
  endtask

  initial begin : slave
    slave_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slave_reset();
      end else begin
        monitor();
        // B and R are evaluated before the address/data channels so a response
        // can never coincide with the handshake it answers.
        if (b_drop) begin
          bvalid = 1'b0; b_drop = 1'b0; aw_taken = 1'b0; w_taken = 1'b0;
          new_wdelays();
        end else if (bvalid && bready) begin
          b_drop = 1'b1; b_n++;
        end else if (!bvalid && aw_taken && w_taken) begin
          if (b_dly == 0) begin
            bvalid = 1'b1;
            bresp  = (b_n == bad_b_idx) ? 2'b10 : 2'b00;
            mem[slot(wr_addr_cap)] = wr_data_cap;
          end else b_dly--;
        end
        if (r_drop) begin
          rvalid = 1'b0; r_drop = 1'b0; ar_taken = 1'b0;
          new_rdelays();
        end else if (rvalid && rready) begin
          r_drop = 1'b1; r_n++;
        end else if (!rvalid && ar_taken) begin
          if (r_dly == 0) begin
            rvalid = 1'b1;
            rdata  = (r_n == corrupt_idx) ? 32'hDEAD_BEEF : mem[slot(rd_addr_cap)];
            rresp  = (r_n == bad_r_idx) ? 2'b10 : 2'b00;
          end else r_dly--;
        end
        awready = 1'b0;
        if (awvalid && !aw_taken) begin
          if (aw_dly == 0) begin
            awready = 1'b1; aw_taken = 1'b1; wr_addr_cap = awaddr;
            check_eq("wr_addr", 64'(awaddr), 64'(BASE + 32'(4 * aw_n)));
            aw_n++;
          end else aw_dly--;
        end else if (!awvalid && early_rdy) awready = (rnd(1) == 1);
        wready = 1'b0;
        if (wvalid && !w_taken) begin
          if (w_dly == 0) begin
            wready = 1'b1; w_taken = 1'b1; wr_data_cap = wdata;
            check_eq("wr_data", 64'(wdata), 64'(START + 32'(w_n)));
            check_eq("wstrb_prot", 64'({wstrb, awprot, arprot}), 64'({4'hF, 6'b0}));
            w_n++;
          end else w_dly--;
        end else if (!wvalid && early_rdy) wready = (rnd(1) == 1);
        arready = 1'b0;
        if (arvalid && !ar_taken) begin
          if (ar_dly == 0) begin
            arready = 1'b1; ar_taken = 1'b1; rd_addr_cap = araddr;
            check_eq("rd_addr", 64'(araddr), 64'(BASE + 32'(4 * ar_n)));
            ar_n++;
          end else ar_dly--;
        end else if (!arvalid && early_rdy) arready = (rnd(1) == 1);
        last_awv = awvalid; last_awr = awready; last_awaddr = awaddr;
        last_wv  = wvalid;  last_wr  = wready;  last_wdata  = wdata;
        last_arv = arvalid; last_arr = arready; last_araddr = araddr;
        last_bready = bready; last_rready = rready;
      end
    end
  end

  task automatic set_cfg(input int md, input bit wf, input bit er, input int c, input int bb, input int br);
    max_dly = md; w_first = wf; early_rdy = er;
    corrupt_idx = c; bad_b_idx = bb; bad_r_idx = br;
  endtask

  task automatic clear_run;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    for (int k = 0; k < N; k++) mem[k] = 32'h0;
    new_wdelays();
    new_rdelays();
  endtask

  task automatic pulse_init(input int cycles);
    init = 1'b1;
    repeat (cycles) @(negedge clk);
    init = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!(txn_done && r_n == N) && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_finished"}, 64'(cyc < TIMEOUT), 64'(1));
  endtask

  task automatic wait_valid(input string tag, input bit rd);
    int cyc;
    cyc = 0;
    while (!(rd ? arvalid : awvalid) && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_seen"}, 64'(rd ? arvalid : awvalid), 64'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valids"}, 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
    check_eq({tag, "_status"}, 64'({txn_done, error}), 64'(0));
    check_eq({tag, "_addr"}, {awaddr, araddr}, {BASE, BASE});
    check_eq({tag, "_wdata"}, 64'(wdata), 64'(START));
  endtask

  // Waits long enough that an unwanted second run would show in the counts.
  task automatic check_run(input string tag, input bit exp_err);
    repeat (50) @(negedge clk);
    check_eq({tag, "_done"}, 64'(txn_done), 64'(1));
    check_eq({tag, "_error"}, 64'(error), 64'(exp_err));
    check_eq({tag, "_counts"}, 64'({8'(aw_n), 8'(w_n), 8'(b_n), 8'(ar_n), 8'(r_n)}), 64'({5{8'(N)}}));
    for (int k = 0; k < N; k++)
      check_eq({tag, "_mem"}, 64'(mem[k]), 64'(START + 32'(k)));
    check_eq({tag, "_quiet"}, 64'({awvalid, wvalid, arvalid}), 64'(0));
  endtask

  task automatic full_run(input string tag, input int pulse_len);
    clear_run();
    pulse_init(pulse_len);
    wait_done(tag);
    check_run(tag, expect_error());
  endtask

  initial begin : main
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle");

    set_cfg(0, 1'b0, 1'b0, -1, -1, -1); full_run("basic", 2);
    set_cfg(0, 1'b0, 1'b0,  2, -1, -1); full_run("corrupt2", 2);
    set_cfg(0, 1'b0, 1'b0, -1,  1, -1); full_run("bresp1", 2);
    set_cfg(0, 1'b0, 1'b0, -1, -1, -1); full_run("clean_after_err", 2);
    set_cfg(7, 1'b1, 1'b1, -1, -1, -1); full_run("wfirst_rand", 2);
    set_cfg(5, 1'b0, 1'b1, -1, -1,  3); full_run("rresp3", 2);

    for (int t = 0; t < 6; t++) begin
      set_cfg(rnd(7), rnd(1) == 1, rnd(1) == 1, rnd(2 * N - 1), rnd(3 * N - 1), rnd(3 * N - 1));
      full_run("random", 2);
    end

    // asynchronous reset while reads are in progress
    set_cfg(3, 1'b0, 1'b0, -1, -1, -1);
    clear_run();
    pulse_init(2);
    wait_valid("abort_read", 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_run();
    repeat (30) @(negedge clk);
    check_eq("abort_no_resume", 64'({8'(aw_n), 8'(ar_n), awvalid, arvalid, txn_done, error}), 64'(0));
    set_cfg(0, 1'b0, 1'b0, -1, -1, -1); full_run("after_abort", 2);

    // level held for 1 us starts a single run
    set_cfg(0, 1'b0, 1'b0, -1, -1, -1); full_run("held_high", 100);

    // a second edge while writing is ignored
    set_cfg(2, 1'b0, 1'b0, -1, -1, -1);
    clear_run();
    pulse_init(2);
    wait_valid("repulse_write", 1'b0);
    pulse_init(2);
    wait_done("repulse");
    check_run("repulse", expect_error());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
